// File: rtl/jtframe_neptuno_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_neptuno_pkg
//  Description : Shared constants for the Neptuno DB9 Megadrive pad reader:
//                button bit positions in the 12-bit joystick word, the scan
//                FSM state encoding, the select-phase numbers that carry
//                data and a helper that recognises the 6-button ID phase.
//  Revision    : 1.0  initial release
// ============================================================================
package jtframe_neptuno_pkg;

    // Width of the decoded joystick word.
    localparam int c_JOY_W = 12;

    // Bit positions inside joy1/joy2 (active-high).
    localparam int c_BTN_R     = 0;
    localparam int c_BTN_L     = 1;
    localparam int c_BTN_D     = 2;
    localparam int c_BTN_U     = 3;
    localparam int c_BTN_A     = 4;
    localparam int c_BTN_Y     = 5;
    localparam int c_BTN_C     = 6;
    localparam int c_BTN_B     = 7;
    localparam int c_BTN_X     = 8;
    localparam int c_BTN_Z     = 9;
    localparam int c_BTN_START = 10;
    localparam int c_BTN_MODE  = 11;

    // Scan FSM encoding. DONE is the single commit cycle that closes a
    // SCAN before the machine falls back to IDLE.
    localparam int         c_ST_W    = 2;
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SCAN = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Select phases, eight per frame; even phases drive select low.
    localparam int         c_PH_W      = 3;
    localparam logic [2:0] c_PH_FIRST  = 3'd0;  // Start, A
    localparam logic [2:0] c_PH_DPAD   = 3'd1;  // U D L R B C
    localparam logic [2:0] c_PH_ID     = 3'd4;  // 6-button signature
    localparam logic [2:0] c_PH_EXTRA  = 3'd5;  // Z Y X Mode
    localparam logic [2:0] c_PH_LAST   = 3'd7;

    // A 6-button pad pulls all four direction pins low on its third
    // select-low pulse; a 3-button pad cannot, as U/D still follow the
    // stick there.
    function automatic logic is_six_id(input logic [3:0] dirs);
        return dirs == 4'b0000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_neptuno_db9_dec.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_neptuno_db9_dec
//  Description : One DB9 port: 2-flop input synchronizer, per-phase capture
//                of the Megadrive pad pins and a committed output word.
//  Ports       : clk, reset     - system clock, synchronous active-high reset
//                i_bus[5:0]     - raw active-low DB9 pins
//                i_sample       - last clock of the current select phase
//                i_ph[2:0]      - current select phase
//                i_commit       - copy capture registers to the outputs
//                o_joy[11:0]    - committed buttons, active-high
//                o_six          - committed 6-button detection flag
//  Revision    : 1.0  initial release
// ============================================================================
module jtframe_neptuno_db9_dec
    import jtframe_neptuno_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         i_bus,
    input  logic               i_sample,
    input  logic [c_PH_W-1:0]  i_ph,
    input  logic               i_commit,
    output logic [c_JOY_W-1:0] o_joy,
    output logic               o_six
);

    logic [5:0]         r_sync1;
    logic [5:0]         r_sync2;
    logic [c_JOY_W-1:0] r_cap;
    logic               r_six_cap;
    logic [c_JOY_W-1:0] r_joy;
    logic               r_six;
    logic [5:0]         w_bus;

    assign w_bus = r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Synchronizer idles at the released (all-ones) pin level so
            // nothing looks pressed straight out of reset.
            r_sync1   <= '1;
            r_sync2   <= '1;
            r_cap     <= '0;
            r_six_cap <= 1'b0;
            r_joy     <= '0;
            r_six     <= 1'b0;
        end else begin
            r_sync1 <= i_bus;
            r_sync2 <= r_sync1;

            if (i_sample) begin
                case (i_ph)
                    c_PH_FIRST: begin
                        r_cap[c_BTN_START] <= ~w_bus[5];
                        r_cap[c_BTN_A]     <= ~w_bus[4];
                    end
                    c_PH_DPAD: begin
                        r_cap[c_BTN_U] <= ~w_bus[0];
                        r_cap[c_BTN_D] <= ~w_bus[1];
                        r_cap[c_BTN_L] <= ~w_bus[2];
                        r_cap[c_BTN_R] <= ~w_bus[3];
                        r_cap[c_BTN_B] <= ~w_bus[4];
                        r_cap[c_BTN_C] <= ~w_bus[5];
                    end
                    c_PH_ID: begin
                        r_six_cap <= is_six_id(w_bus[3:0]);
                    end
                    c_PH_EXTRA: begin
                        // Without the ID signature these pins carry the
                        // plain d-pad again, so the extra buttons are zeroed.
                        r_cap[c_BTN_Z]    <= r_six_cap & ~w_bus[0];
                        r_cap[c_BTN_Y]    <= r_six_cap & ~w_bus[1];
                        r_cap[c_BTN_X]    <= r_six_cap & ~w_bus[2];
                        r_cap[c_BTN_MODE] <= r_six_cap & ~w_bus[3];
                    end
                    default: ;
                endcase
            end

            if (i_commit) begin
                r_joy <= r_cap;
                r_six <= r_six_cap;
            end
        end
    end

    assign o_joy = r_joy;
    assign o_six = r_six;

endmodule
`default_nettype wire

// File: rtl/jtframe_neptuno_db9.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_neptuno_db9
//  Description : Reads two Megadrive 3/6-button pads on the Neptuno DB9
//                ports through one shared select line. A frame is an IDLE
//                wait with select high (lets 6-button pads reset their
//                internal counter), eight select phases of STEP_CYC clocks,
//                and one commit cycle.
//  Ports       : clk         - system clock
//                reset       - synchronous active-high reset
//                joy1_bus    - DB9 port 1 raw pins, active-low
//                joy2_bus    - DB9 port 2 raw pins, active-low
//                joy_select  - shared Megadrive select line
//                joy1, joy2  - decoded buttons, active-high
//                six_btn     - per-port 6-button pad flag
//                frame_done  - one-cycle pulse when the outputs update
//  Revision    : 1.0  initial release
// ============================================================================
module jtframe_neptuno_db9
    import jtframe_neptuno_pkg::*;
#(
    parameter int STEP_CYC = 256,
    parameter int IDLE_CYC = 131072
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         joy1_bus,
    input  logic [5:0]         joy2_bus,
    output logic               joy_select,
    output logic [c_JOY_W-1:0] joy1,
    output logic [c_JOY_W-1:0] joy2,
    output logic [1:0]         six_btn,
    output logic               frame_done
);

    localparam int c_CNT_MAX = (IDLE_CYC > STEP_CYC) ? IDLE_CYC : STEP_CYC;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_IDLE_LAST = c_CNT_W'(IDLE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_STEP_LAST = c_CNT_W'(STEP_CYC - 1);

    logic [c_ST_W-1:0]  r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_PH_W-1:0]  r_ph;
    logic               r_select;
    logic               r_frame_done;

    logic [c_ST_W-1:0]  w_state_nx;
    logic [c_CNT_W-1:0] w_cnt_nx;
    logic [c_PH_W-1:0]  w_ph_nx;
    logic               w_select_nx;
    logic               w_sample;
    logic               w_commit;

    // ------------------------------------------------------------------
    // State, counter and registered select line
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_ph         <= '0;
            r_select     <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_ph         <= w_ph_nx;
            r_select     <= w_select_nx;
            r_frame_done <= w_commit;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The select line is registered from the next
    // state so it changes on the same edge the phase does, glitch free.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_ph_nx    = r_ph;
        w_sample   = 1'b0;
        w_commit   = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (r_cnt == c_IDLE_LAST) begin
                    w_state_nx = c_ST_SCAN;
                    w_cnt_nx   = '0;
                    w_ph_nx    = '0;
                end
            end
            c_ST_SCAN: begin
                if (r_cnt == c_STEP_LAST) begin
                    w_sample = 1'b1;
                    w_cnt_nx = '0;
                    w_ph_nx  = r_ph + 1'b1;
                    if (r_ph == c_PH_LAST) begin
                        w_state_nx = c_ST_DONE;
                    end
                end
            end
            c_ST_DONE: begin
                w_commit   = 1'b1;
                w_state_nx = c_ST_IDLE;
                w_cnt_nx   = '0;
            end
            default: begin
                w_state_nx = c_ST_IDLE;
                w_cnt_nx   = '0;
                w_ph_nx    = '0;
            end
        endcase

        w_select_nx = (w_state_nx == c_ST_SCAN) ? w_ph_nx[0] : 1'b1;
    end

    // ------------------------------------------------------------------
    // Per-port synchronizer and capture
    // ------------------------------------------------------------------
    logic [5:0]         w_bus [2];
    logic [c_JOY_W-1:0] w_joy [2];
    logic [1:0]         w_six;

    assign w_bus[0] = joy1_bus;
    assign w_bus[1] = joy2_bus;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        jtframe_neptuno_db9_dec u_dec (
            .clk      (clk),
            .reset    (reset),
            .i_bus    (w_bus[gi]),
            .i_sample (w_sample),
            .i_ph     (r_ph),
            .i_commit (w_commit),
            .o_joy    (w_joy[gi]),
            .o_six    (w_six[gi])
        );
    end

    assign joy_select = r_select;
    assign joy1       = w_joy[0];
    assign joy2       = w_joy[1];
    assign six_btn    = w_six;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: doc/jtframe_neptuno_db9.md
JTFRAME_NEPTUNO_DB9 -- requirements
Module: jtframe_neptuno_db9

Interface
REQ-001 SHALL have parameter STEP_CYC, default 256, clocks per select phase (>=4).
REQ-002 SHALL have parameter IDLE_CYC, default 131072, clocks with select high between scan frames (pad counter reset).
REQ-003 SHALL have port clk  input  1  system clock; the block has one clock only.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port joy1_bus  input  6  DB9 port 1, active-low, raw pins.
REQ-006 SHALL have port joy2_bus  input  6  DB9 port 2, active-low, raw pins.
REQ-007 SHALL have port joy_select  output  1  shared Megadrive select line.
REQ-008 SHALL have port joy1  output  12  port 1 buttons, active-high.
REQ-009 SHALL have port joy2  output  12  port 2 buttons, active-high.
REQ-010 SHALL have port six_btn  output  2  per-port 6-button pad detected in last frame.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse when outputs update.

Function
REQ-012 SHALL map outputs as: bit0 R, 1 L, 2 D, 3 U, 4 A, 5 Y, 6 C, 7 B, 8 X, 9 Z, 10 Start, 11 Mode.
REQ-013 SHALL pass each bus through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-014 SHALL implement FSM IDLE -> SCAN -> IDLE; IDLE holds joy_select=1 for IDLE_CYC clocks, then enters SCAN with phase ph=0.
REQ-015 SHALL, in SCAN, drive joy_select=ph[0] (ph even low, odd high) for STEP_CYC clocks per phase, ph 0..7.
REQ-016 SHALL sample both ports on the last clock of each phase only.
REQ-017 SHALL capture in ph0: Start=~bus[5], A=~bus[4].
REQ-018 SHALL capture in ph1: U=~bus[0], D=~bus[1], L=~bus[2], R=~bus[3], B=~bus[4], C=~bus[5].
REQ-019 SHALL set the per-port six-button flag in ph4 iff bus[3:0]==4'b0000.
REQ-020 SHALL capture in ph5, only if the flag is set: Z=~bus[0], Y=~bus[1], X=~bus[2], Mode=~bus[3]; otherwise X/Y/Z/Mode = 0.
REQ-021 SHALL, on the clock after the ph7 sample, commit joy1, joy2 and six_btn together, pulse frame_done for exactly one cycle, and return to IDLE.
REQ-022 SHALL hold joy1/joy2/six_btn stable between commits; partial frame data is never visible.
REQ-023 SHALL produce frame period IDLE_CYC + 8*STEP_CYC + 1 clocks.
REQ-024 SHALL report all-zero buttons and six_btn=0 for a disconnected port (bus all ones).

Reset
REQ-025 SHALL, while reset=1: state IDLE, joy_select=1, joy1=joy2=0, six_btn=0, frame_done=0, counters and capture registers cleared.
REQ-026 SHALL abort a scan when reset asserts mid-frame, without a frame_done pulse and without an output update; after release, a full IDLE_CYC wait precedes the next SCAN.

Structure
REQ-027 SHALL take the button bit-index constants (REQ-012) and the FSM state encoding from shared package jtframe_neptuno_pkg.
REQ-028 SHALL instantiate the per-port synchronizer plus capture logic twice as sub-module jtframe_neptuno_db9_dec; the FSM, counters and select live in the top module.

Verification (STEP_CYC=8, IDLE_CYC=32)
REQ-029 SHALL check reset: outputs 0 and select 1; first select fall 32 clocks after reset release; frame_done every 97 clocks.
REQ-030 SHALL check a 3-button pad model on port 1 holding Start+C: joy1=12'h440, six_btn[0]=0.
REQ-031 SHALL check a 6-button pad model on port 2 holding X+Mode: joy2=12'h900, six_btn[1]=1.
REQ-032 SHALL check port 1 with Up+Right held and port 2 unplugged: joy1=12'h009, joy2=12'h000, six_btn=2'b00.
REQ-033 SHALL check reset pulsed during ph3: select=1 on the next cycle, outputs 0, no frame_done, and a clean frame 97 clocks after release.
REQ-034 SHALL check a button change mid-frame (after ph1): it is reported only in the following frame.
